uni_shift_ctrl: RTL and testbench
=================================

UNI_SHIFT_CTRL -- requirements
Module: uni_shift_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the data word and of the downstream universal shift register.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-003 SHALL have port clear_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1: the block accepts a command this cycle.
REQ-006 SHALL have port cmd_dir, input, 1: 0 = shift right, 1 = shift left.
REQ-007 SHALL have port cmd_data, input, WIDTH: the word to parallel-load.
REQ-008 SHALL have port cmd_count, input, 3: the number of shifts after the load.
REQ-009 SHALL have port ser_in, input, 1: the serial fill bit used during shifts.
REQ-010 SHALL have port S, output, 2: the mode for the downstream register (00 hold, 01 shift right, 10 shift left, 11 parallel load).
REQ-011 SHALL have port I, output, WIDTH: the parallel-load data for the downstream register.
REQ-012 SHALL have ports SIR and SIL, output, 1 each: the serial inputs for right and left shifts.
REQ-013 SHALL have port ser_out, output, 1, and ser_out_valid, output, 1: the bit leaving the register on each shift.
REQ-014 SHALL have port shadow, output, WIDTH: a mirror of the downstream register contents.
REQ-015 SHALL have ports busy, output, 1, and done, output, 1: busy is high while a command is in progress; done is a one-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE, all held in registers.
REQ-017 SHALL assert cmd_ready only in IDLE; a command is accepted on a clock edge where cmd_valid and cmd_ready are both high.
REQ-018 SHALL, on accept, capture cmd_data, cmd_dir and the shift count, and go IDLE->LOAD.
REQ-019 SHALL saturate the captured shift count to WIDTH when cmd_count exceeds WIDTH.
REQ-020 SHALL in LOAD drive S=11 and I=captured data for exactly one cycle, and load shadow with the captured data at the edge that ends LOAD.
REQ-021 SHALL go LOAD->DONE when the count is 0, and LOAD->SHIFT otherwise.
REQ-022 SHALL in SHIFT drive S=01 (dir 0) or S=10 (dir 1) for exactly count cycles, then go to DONE.
REQ-023 SHALL in SHIFT with dir 0 pass SIR=ser_in combinationally with SIL=0, and update shadow to {ser_in, shadow[WIDTH-1:1]}.
REQ-024 SHALL in SHIFT with dir 1 pass SIL=ser_in combinationally with SIR=0, and update shadow to {shadow[WIDTH-2:0], ser_in}.
REQ-025 SHALL in SHIFT drive ser_out_valid=1, with ser_out=shadow[0] for dir 0 or ser_out=shadow[WIDTH-1] for dir 1; outside SHIFT, ser_out_valid=0 and ser_out=0.
REQ-026 SHALL in DONE drive S=00 and done=1 for one cycle, then go to IDLE; a new command can be accepted in the IDLE cycle that follows.
REQ-027 SHALL drive busy=1 in LOAD, SHIFT and DONE; outside LOAD, I=0; in IDLE, S=00.
REQ-028 SHALL ignore cmd_valid while busy, with no queuing and no change to the captured fields.
REQ-029 SHALL make S, I, cmd_ready, busy and done functions of registered state only (Moore); only SIL and SIR depend combinationally on an input.

Reset
REQ-030 SHALL, while clear_n=0, immediately force state IDLE, shadow=0, captured fields=0, S=00, I=0, SIL=SIR=0, ser_out=ser_out_valid=0, busy=0, done=0 and cmd_ready=1.
REQ-031 SHALL, when reset is asserted mid-LOAD or mid-SHIFT, abort the operation with no done pulse, and accept a new command in the first cycle after clear_n rises.

Verification
REQ-032 SHALL verify reset: clear_n low for 2 cycles, release -> S=00, I=0000, shadow=0000, cmd_ready=1, busy=0.
REQ-033 SHALL verify load only: data 1011, count 0, dir 0 -> one cycle with S=11, I=1011; next cycle done=1, S=00; shadow=1011.
REQ-034 SHALL verify right shift: data 1011, count 2, dir 0, ser_in=1 -> S=01 for 2 cycles, ser_out 1 then 1, shadow 1101 then 1110, then done.
REQ-035 SHALL verify left shift with saturation: data 1001, count 7, dir 1, ser_in=0 -> exactly 4 shift cycles, ser_out 1,0,0,1, shadow=0000, then done.
REQ-036 SHALL verify busy handling: cmd_valid held high during busy -> cmd_ready=0 and no second accept until IDLE; back-to-back commands accepted one cycle after done.
REQ-037 SHALL verify reset mid-shift: clear_n pulsed low in the 2nd SHIFT cycle -> immediate IDLE outputs, no done; the next command completes normally.

Source files
------------

// File: rtl/uni_shift_ctrl.sv
// Sequencer for a downstream universal shift register: takes one load+shift command
// at a time and drives mode/data/serial lines, keeping a shadow copy of the register.
module uni_shift_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [2:0]       cmd_count,
    input  logic             ser_in,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] I,
    output logic             SIR,
    output logic             SIL,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic [WIDTH-1:0] shadow,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // LOAD  | one cycle of parallel load (S=11)
    // SHIFT | shift down-counter running, one shift per cycle
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter must hold WIDTH itself, and never be narrower than the command field.
    localparam int CW = ($clog2(WIDTH + 1) > 3) ? $clog2(WIDTH + 1) : 3;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CW-1:0]    cnt_sat;

    always_comb begin
        cnt_sat = CW'(cmd_count);
        if (cnt_sat > CW'(WIDTH)) begin
            cnt_sat = CW'(WIDTH);
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    data_d  = cmd_data;
                    dir_d   = cmd_dir;
                    cnt_d   = cnt_sat;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shadow_d = data_q;
                state_d  = (cnt_q == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (dir_q) begin
                    shadow_d = {shadow_q[WIDTH-2:0], ser_in};
                end else begin
                    shadow_d = {ser_in, shadow_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Everything except SIR/SIL is decoded from registered state only.
    always_comb begin
        S             = 2'b00;
        I             = '0;
        SIR           = 1'b0;
        SIL           = 1'b0;
        ser_out       = 1'b0;
        ser_out_valid = 1'b0;
        cmd_ready     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_LOAD: begin
                S    = 2'b11;
                I    = data_q;
                busy = 1'b1;
            end
            ST_SHIFT: begin
                busy          = 1'b1;
                ser_out_valid = 1'b1;
                if (dir_q) begin
                    S       = 2'b10;
                    SIL     = ser_in;
                    ser_out = shadow_q[WIDTH-1];
                end else begin
                    S       = 2'b01;
                    SIR     = ser_in;
                    ser_out = shadow_q[0];
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign shadow = shadow_q;

endmodule

// File: tb/tb_uni_shift_ctrl.sv
// Randomized and directed bench for uni_shift_ctrl, checked against an arithmetic
// model of the load-then-shift sequence.
module tb_uni_shift_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clear_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_dir;
    logic [W-1:0] cmd_data;
    logic [2:0]   cmd_count;
    logic         ser_in;
    logic [1:0]   S;
    logic [W-1:0] I;
    logic         SIR;
    logic         SIL;
    logic         ser_out;
    logic         ser_out_valid;
    logic [W-1:0] shadow;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] m_shadow;

    always #5 clk = ~clk;

    uni_shift_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .clear_n       (clear_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_dir       (cmd_dir),
        .cmd_data      (cmd_data),
        .cmd_count     (cmd_count),
        .ser_in        (ser_in),
        .S             (S),
        .I             (I),
        .SIR           (SIR),
        .SIL           (SIL),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .shadow        (shadow),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_S"},     32'(S), 32'd0);
        chk({tag, "_I"},     32'(I), 32'd0);
        chk({tag, "_sov"},   32'(ser_out_valid), 32'd0);
        chk({tag, "_so"},    32'(ser_out), 32'd0);
        chk({tag, "_sir"},   32'(SIR), 32'd0);
        chk({tag, "_sil"},   32'(SIL), 32'd0);
    endtask

    // Starts at a negedge in IDLE, ends at the negedge of the following IDLE cycle.
    // hold keeps cmd_valid high with scrambled fields for the whole busy period.
    task automatic run_cmd(input string tag, input logic [W-1:0] data, input logic dir,
                           input logic [2:0] cnt, input bit hold, input int sin_sel);
        int   n;
        int   waited;
        logic sin;
        logic exp_bit;
        waited = 0;
        while (!cmd_ready && waited < 16) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        chk({tag, "_ready_wait"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_S"}, 32'(S), 32'd0);
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_dir   = dir;
        cmd_count = cnt;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            cmd_data  = ~data;
            cmd_dir   = ~dir;
            cmd_count = 3'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        n = (int'(cnt) > W) ? W : int'(cnt);
        chk({tag, "_load_S"}, 32'(S), 32'd3);
        chk({tag, "_load_I"}, 32'(I), 32'(data));
        chk({tag, "_load_busy"}, 32'(busy), 32'd1);
        chk({tag, "_load_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_load_done"}, 32'(done), 32'd0);
        chk({tag, "_load_sov"}, 32'(ser_out_valid), 32'd0);
        m_shadow = data;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            sin = (sin_sel < 0) ? 1'($urandom % 2) : sin_sel[0];
            ser_in = sin;
            #1;
            exp_bit = dir ? m_shadow[W-1] : m_shadow[0];
            chk({tag, "_sh_S"}, 32'(S), dir ? 32'd2 : 32'd1);
            chk({tag, "_sh_I"}, 32'(I), 32'd0);
            chk({tag, "_sh_sov"}, 32'(ser_out_valid), 32'd1);
            chk({tag, "_sh_so"}, 32'(ser_out), 32'(exp_bit));
            chk({tag, "_sh_shadow"}, 32'(shadow), 32'(m_shadow));
            chk({tag, "_sh_sir"}, 32'(SIR), dir ? 32'd0 : 32'(sin));
            chk({tag, "_sh_sil"}, 32'(SIL), dir ? 32'(sin) : 32'd0);
            chk({tag, "_sh_ready"}, 32'(cmd_ready), 32'd0);
            chk({tag, "_sh_done"}, 32'(done), 32'd0);
            if (dir) begin
                m_shadow = W'((int'(m_shadow) * 2 + int'(sin)) % (1 << W));
            end else begin
                m_shadow = W'(int'(m_shadow) / 2 + int'(sin) * (1 << (W - 1)));
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_S"}, 32'(S), 32'd0);
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd1);
        chk({tag, "_done_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_done_sov"}, 32'(ser_out_valid), 32'd0);
        chk({tag, "_done_shadow"}, 32'(shadow), 32'(m_shadow));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_after_done"}, 32'(done), 32'd0);
        chk({tag, "_after_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_after_shadow"}, 32'(shadow), 32'(m_shadow));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_data  = '0;
        cmd_count = '0;
        ser_in    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("rst_low");
        chk("rst_low_shadow", 32'(shadow), 32'd0);
        clear_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("rst_rel");
        chk("rst_rel_shadow", 32'(shadow), 32'd0);

        run_cmd("load_only", 4'b1011, 1'b0, 3'd0, 1'b0, 0);
        chk("load_only_shadow", 32'(shadow), 32'b1011);

        run_cmd("right2", 4'b1011, 1'b0, 3'd2, 1'b0, 1);
        chk("right2_shadow", 32'(shadow), 32'b1110);

        run_cmd("left_sat", 4'b1001, 1'b1, 3'd7, 1'b0, 0);
        chk("left_sat_shadow", 32'(shadow), 32'b0000);

        run_cmd("hold_a", 4'b0110, 1'b1, 3'd3, 1'b1, -1);
        run_cmd("hold_b", 4'b1100, 1'b0, 3'd1, 1'b1, -1);
        run_cmd("hold_c", 4'b0011, 1'b0, 3'd5, 1'b0, -1);

        // Reset pulse in the second shift cycle of a 3-shift right command.
        cmd_valid = 1'b1;
        cmd_data  = 4'b1011;
        cmd_dir   = 1'b0;
        cmd_count = 3'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("midrst_load_S", 32'(S), 32'd3);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        ser_in = 1'b1;
        #1;
        chk("midrst_shift_S", 32'(S), 32'd1);
        clear_n = 1'b0;
        #1;
        check_idle("midrst_async");
        chk("midrst_shadow", 32'(shadow), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_idle("midrst_held");
        clear_n = 1'b1;
        run_cmd("post_rst", 4'b0101, 1'b1, 3'd2, 1'b0, -1);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_nodone", 32'(done), 32'd0);

        for (int r = 0; r < 30; r++) begin
            run_cmd("rand", W'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), -1);
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
